sprite_renderer: RTL

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_hit.sv | 32 +++
 rtl/sprite_renderer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer.
package sprite_pkg;
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    LAYER_BG    = 2'd0,
    LAYER_PAC   = 2'd1,
    LAYER_GHOST = 2'd2,
    LAYER_FRUIT = 2'd3
  } layer_e;

  typedef enum logic {
    PHASE_OPEN   = 1'b0,
    PHASE_CLOSED = 1'b1
  } phase_e;

  localparam int unsigned SPRITE_DIM = 8;
endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test and ROM row/column derivation for one scaled sprite.
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  output logic       hit,
  output logic [2:0] row,
  output logic [2:0] col
);
  localparam logic [10:0] SPAN = 11'(SPRITE_DIM << SCALE_SHIFT);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [9:0]  dx_s;
  logic [9:0]  dy_s;

  // Bit 10 is the sign of the difference; a negative offset never hits.
  always_comb begin
    dx   = {1'b0, draw_x} - {1'b0, sx};
    dy   = {1'b0, draw_y} - {1'b0, sy};
    hit  = !dx[10] && !dy[10] && (dx < SPAN) && (dy < SPAN);
    dx_s = dx[9:0] >> SCALE_SHIFT;
    dy_s = dy[9:0] >> SCALE_SHIFT;
    col  = dx_s[2:0];
    row  = dy_s[2:0];
  end
endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pixel pipeline: stage 1 hit-tests sprites and addresses the ROMs,
// stage 2 reads ROM bits and resolves layer priority.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       pix_valid_in,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  input  logic [9:0] ghost_x,
  input  logic [9:0] ghost_y,
  input  logic [9:0] fruit_x,
  input  logic [9:0] fruit_y,
  input  logic [1:0] pac_dir,
  input  logic       fruit_en,
  output logic [2:0] row_addr_pac,
  output logic [2:0] row_addr_ghost,
  output logic [2:0] row_addr_fruit,
  input  logic [7:0] rom_right,
  input  logic [7:0] rom_closed,
  input  logic [7:0] rom_up,
  input  logic [7:0] rom_ghost,
  input  logic [7:0] rom_fruit,
  output logic       pix_valid_out,
  output logic [1:0] pixel_layer
);
  localparam int unsigned CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  logic [CNT_W-1:0] anim_cnt;
  phase_e           phase;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      anim_cnt <= '0;
      phase    <= PHASE_OPEN;
    end else if (frame_tick) begin
      if (anim_cnt == CNT_LAST) begin
        anim_cnt <= '0;
        phase    <= (phase == PHASE_OPEN) ? PHASE_CLOSED : PHASE_OPEN;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  logic       hit_pac, hit_ghost, hit_fruit;
  logic [2:0] row_pac, row_ghost, row_fruit;
  logic [2:0] col_pac, col_ghost, col_fruit;

  sprite_hit #(.SCALE_SHIFT(SCALE_SHIFT)) u_hit_pac (
    .draw_x(DrawX), .draw_y(DrawY), .sx(pac_x), .sy(pac_y),
    .hit(hit_pac), .row(row_pac), .col(col_pac)
  );
  sprite_hit #(.SCALE_SHIFT(SCALE_SHIFT)) u_hit_ghost (
    .draw_x(DrawX), .draw_y(DrawY), .sx(ghost_x), .sy(ghost_y),
    .hit(hit_ghost), .row(row_ghost), .col(col_ghost)
  );
  sprite_hit #(.SCALE_SHIFT(SCALE_SHIFT)) u_hit_fruit (
    .draw_x(DrawX), .draw_y(DrawY), .sx(fruit_x), .sy(fruit_y),
    .hit(hit_fruit), .row(row_fruit), .col(col_fruit)
  );

  dir_e       pac_dir_e;
  logic       s1_valid, s1_hit_pac, s1_hit_ghost, s1_hit_fruit;
  logic [2:0] s1_col_pac, s1_col_ghost, s1_col_fruit;
  dir_e       s1_dir;
  phase_e     s1_phase;

  assign pac_dir_e = dir_e'(pac_dir);

  // Down reuses the up ROM flipped vertically via the row address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid       <= 1'b0;
      s1_hit_pac     <= 1'b0;
      s1_hit_ghost   <= 1'b0;
      s1_hit_fruit   <= 1'b0;
      s1_col_pac     <= '0;
      s1_col_ghost   <= '0;
      s1_col_fruit   <= '0;
      s1_dir         <= DIR_RIGHT;
      s1_phase       <= PHASE_OPEN;
      row_addr_pac   <= '0;
      row_addr_ghost <= '0;
      row_addr_fruit <= '0;
    end else begin
      s1_valid       <= pix_valid_in;
      s1_hit_pac     <= hit_pac;
      s1_hit_ghost   <= hit_ghost;
      s1_hit_fruit   <= hit_fruit & fruit_en;
      s1_col_pac     <= col_pac;
      s1_col_ghost   <= col_ghost;
      s1_col_fruit   <= col_fruit;
      s1_dir         <= pac_dir_e;
      s1_phase       <= phase;
      row_addr_pac   <= (pac_dir_e == DIR_DOWN) ? 3'd7 - row_pac : row_pac;
      row_addr_ghost <= row_ghost;
      row_addr_fruit <= row_fruit;
    end
  end

  logic [7:0] pac_row;
  logic [2:0] pac_bit, ghost_bit, fruit_bit;
  logic       pac_on, ghost_on, fruit_on;
  layer_e     layer_nxt;

  // Left reuses the right ROM mirrored horizontally via the bit index.
  always_comb begin
    pac_row   = rom_right;
    if (s1_phase == PHASE_CLOSED)                     pac_row = rom_closed;
    else if (s1_dir == DIR_UP || s1_dir == DIR_DOWN)  pac_row = rom_up;
    pac_bit   = (s1_dir == DIR_LEFT) ? s1_col_pac : 3'd7 - s1_col_pac;
    ghost_bit = 3'd7 - s1_col_ghost;
    fruit_bit = 3'd7 - s1_col_fruit;
    pac_on    = s1_hit_pac   & pac_row[pac_bit];
    ghost_on  = s1_hit_ghost & rom_ghost[ghost_bit];
    fruit_on  = s1_hit_fruit & rom_fruit[fruit_bit];
    layer_nxt = LAYER_BG;
    if (s1_valid) begin
      if (ghost_on)      layer_nxt = LAYER_GHOST;
      else if (pac_on)   layer_nxt = LAYER_PAC;
      else if (fruit_on) layer_nxt = LAYER_FRUIT;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid_out <= 1'b0;
      pixel_layer   <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      pixel_layer   <= layer_nxt;
    end
  end
endmodule
